// File: rtl/hex_disp_ctrl_pkg.sv
// Shared parameters, FSM encoding and BCD helper for the hex/decimal display controller.
package hex_disp_ctrl_pkg;

  localparam int          NUM_DIGITS = 6;
  localparam int          VALUE_W    = 20;
  localparam int unsigned DEC_MAX    = 999999;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Shift-add-3 correction applied to each BCD digit before every shift.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/hex_disp_ctrl_if.sv
// Request/result bundle between a display client and hex_disp_ctrl.
interface hex_disp_ctrl_if #(
  parameter int NUM_DIGITS = hex_disp_ctrl_pkg::NUM_DIGITS,
  parameter int VALUE_W    = hex_disp_ctrl_pkg::VALUE_W
);
  logic [VALUE_W-1:0]      value;
  logic                    load;
  logic                    mode;
  logic                    lzb;
  logic [NUM_DIGITS-1:0]   dotin;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   en;
  logic [NUM_DIGITS-1:0]   dot;
  logic                    busy;
  logic                    done;
  logic                    ovf;

  modport master (
    output value, load, mode, lzb, dotin,
    input  digits, en, dot, busy, done, ovf
  );

  modport slave (
    input  value, load, mode, lzb, dotin,
    output digits, en, dot, busy, done, ovf
  );
endinterface

// File: rtl/hex_disp_ctrl_bin2bcd.sv
// Sequential shift-add-3 binary to BCD converter, one input bit per cycle.
// done flags the cycle whose closing edge performs the final shift.
module bin2bcd_seq #(
  parameter int VALUE_W    = hex_disp_ctrl_pkg::VALUE_W,
  parameter int NUM_DIGITS = hex_disp_ctrl_pkg::NUM_DIGITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [VALUE_W-1:0]      bin,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd
);
  import hex_disp_ctrl_pkg::*;

  localparam int DW = 4*NUM_DIGITS;
  localparam int CW = $clog2(VALUE_W+1);

  logic [VALUE_W-1:0] bin_q;
  logic [DW-1:0]      bcd_q;
  logic [DW-1:0]      adj;
  logic [CW-1:0]      cnt;

  always_comb begin
    adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      adj[4*i +: 4] = add3(bcd_q[4*i +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      cnt   <= '0;
      bin_q <= '0;
      bcd_q <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      bin_q <= bin;
      bcd_q <= '0;
    end else if (busy) begin
      bcd_q <= {adj[DW-2:0], bin_q[VALUE_W-1]};
      bin_q <= {bin_q[VALUE_W-2:0], 1'b0};
      cnt   <= cnt + 1'b1;
      if (cnt == CW'(VALUE_W-1)) begin
        busy <= 1'b0;
      end
    end
  end

  assign done = busy && (cnt == CW'(VALUE_W-1));
  assign bcd  = bcd_q;

endmodule

// File: rtl/hex_disp_ctrl.sv
// Converts a binary value to hex or decimal digit nibbles with blanking and decimal points,
// publishing all display outputs together on a single commit edge.
module hex_disp_ctrl #(
  parameter int NUM_DIGITS = hex_disp_ctrl_pkg::NUM_DIGITS,
  parameter int VALUE_W    = hex_disp_ctrl_pkg::VALUE_W
) (
  input  logic           clk,
  input  logic           rst,
  hex_disp_ctrl_if.slave bus
);
  import hex_disp_ctrl_pkg::*;

  localparam int DW = 4*NUM_DIGITS;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t state_q, state_d;
  logic   stage_q;
  logic   accept, bcd_start, prep, commit_fire;
  logic   bcd_busy, bcd_done;
  logic [DW-1:0] bcd;

  logic [VALUE_W-1:0]    cap_value;
  logic                  cap_mode, cap_lzb;
  logic [NUM_DIGITS-1:0] cap_dotin;

  logic [DW-1:0]         src_dig, dig_c, res_dig, dig_q;
  logic [NUM_DIGITS-1:0] en_c, dot_c, res_en, res_dot, en_q, dot_q;
  logic                  ovf_c, res_ovf, ovf_q, done_q;
  logic [IW-1:0]         top;

  bin2bcd_seq #(.VALUE_W(VALUE_W), .NUM_DIGITS(NUM_DIGITS)) u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (bcd_start),
    .bin   (bus.value),
    .busy  (bcd_busy),
    .done  (bcd_done),
    .bcd   (bcd)
  );

  // COMMIT spans two cycles: stage 0 registers the result, stage 1 publishes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stage_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= (state_q == ST_COMMIT) && !stage_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.load) state_d = bus.mode ? ST_CONV : ST_COMMIT;
      ST_CONV:   if (bcd_done) state_d = ST_COMMIT;
      ST_COMMIT: if (stage_q)  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept      = (state_q == ST_IDLE) && bus.load;
    bcd_start   = accept && bus.mode;
    prep        = (state_q == ST_COMMIT) && !stage_q;
    commit_fire = (state_q == ST_COMMIT) && stage_q;
  end

  // Blanking keeps every digit up to the highest nonzero digit or requested dot.
  always_comb begin
    ovf_c   = cap_mode && (32'(cap_value) > DEC_MAX);
    src_dig = cap_mode ? bcd : DW'(cap_value);
    top     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (src_dig[4*i +: 4] != 4'd0 || cap_dotin[i]) top = IW'(i);
    end
    en_c = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      en_c[i] = !cap_lzb || (IW'(i) <= top);
    end
    dig_c = src_dig;
    dot_c = cap_dotin;
    if (ovf_c) begin
      dig_c = '0;
      en_c  = '0;
      dot_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_value <= '0;
      cap_mode  <= 1'b0;
      cap_lzb   <= 1'b0;
      cap_dotin <= '0;
      res_dig   <= '0;
      res_en    <= '0;
      res_dot   <= '0;
      res_ovf   <= 1'b0;
      dig_q     <= '0;
      en_q      <= '0;
      dot_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= commit_fire;
      if (accept) begin
        cap_value <= bus.value;
        cap_mode  <= bus.mode;
        cap_lzb   <= bus.lzb;
        cap_dotin <= bus.dotin;
      end
      if (prep) begin
        res_dig <= dig_c;
        res_en  <= en_c;
        res_dot <= dot_c;
        res_ovf <= ovf_c;
      end
      if (commit_fire) begin
        dig_q <= res_dig;
        en_q  <= res_en;
        dot_q <= res_dot;
        ovf_q <= res_ovf;
      end
    end
  end

  assign bus.digits = dig_q;
  assign bus.en     = en_q;
  assign bus.dot    = dot_q;
  assign bus.ovf    = ovf_q;
  assign bus.done   = done_q;
  assign bus.busy   = (state_q != ST_IDLE) || bcd_busy;

endmodule

// File: tb/tb_hex_disp_ctrl.sv
// Randomised and directed checks of hex_disp_ctrl against an arithmetic reference model.
module tb_hex_disp_ctrl;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_err    = 0;

  logic [23:0] prev_dig;
  logic [5:0]  prev_en, prev_dot;
  logic        prev_ovf;

  hex_disp_ctrl_if bus ();

  hex_disp_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Display contents derived from the value by plain base arithmetic.
  function automatic void model(input int unsigned v, input bit m, input bit l, input bit [5:0] d,
                                output bit [23:0] dig, output bit [5:0] en, output bit [5:0] dot,
                                output bit ovf);
    int unsigned base, y;
    int nlit;
    base = m ? 10 : 16;
    ovf  = m && (v > 999999);
    dig  = '0;
    y    = v;
    for (int i = 0; i < 6; i++) begin
      dig[4*i +: 4] = 4'(y % base);
      y = y / base;
    end
    nlit = 0;
    y    = v;
    while (y != 0) begin
      y = y / base;
      nlit++;
    end
    if (nlit == 0) nlit = 1;
    for (int i = 0; i < 6; i++) begin
      if (d[i] && (i + 1) > nlit) nlit = i + 1;
    end
    en  = l ? 6'((1 << nlit) - 1) : 6'h3f;
    dot = d;
    if (ovf) begin
      dig = '0;
      en  = '0;
      dot = '0;
    end
  endfunction

  task automatic scramble();
    bus.value = 20'($urandom);
    bus.mode  = 1'($urandom);
    bus.lzb   = 1'($urandom);
    bus.dotin = 6'($urandom);
  endtask

  // Issues one request; ex >= 0 re-asserts LOAD at that cycle to probe the ignore rule.
  task automatic run_req(input logic [19:0] v, input logic m, input logic l, input logic [5:0] d,
                         input int ex);
    bit [23:0] e_dig;
    bit [5:0]  e_en, e_dot;
    bit        e_ovf;
    int        seen, lat;
    bit        held;
    model(32'(v), m, l, d, e_dig, e_en, e_dot, e_ovf);
    lat  = m ? 22 : 2;
    seen = -1;
    held = 1'b1;
    @(negedge clk);
    bus.value = v;
    bus.mode  = m;
    bus.lzb   = l;
    bus.dotin = d;
    bus.load  = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      bus.load = (n == ex);
      if (n == 0 || n == ex) scramble();
      if (bus.done === 1'b1) begin
        seen = n;
        break;
      end
      if (bus.busy !== 1'b1 || bus.digits !== prev_dig || bus.en !== prev_en ||
          bus.dot !== prev_dot || bus.ovf !== prev_ovf) held = 1'b0;
    end
    bus.load = 1'b0;
    chk("latency", 32'(seen), 32'(lat));
    chk("hold_while_busy", 32'(held), 32'd1);
    chk("digits", 32'(bus.digits), 32'(e_dig));
    chk("en", 32'(bus.en), 32'(e_en));
    chk("dot", 32'(bus.dot), 32'(e_dot));
    chk("ovf", 32'(bus.ovf), 32'(e_ovf));
    chk("busy_at_commit", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("done_single", 32'(bus.done), 32'd0);
    chk("busy_after", 32'(bus.busy), 32'd0);
    prev_dig = e_dig;
    prev_en  = e_en;
    prev_dot = e_dot;
    prev_ovf = e_ovf;
  endtask

  initial begin
    bit saw_done;
    rst       = 1'b1;
    bus.load  = 1'b0;
    bus.value = '0;
    bus.mode  = 1'b0;
    bus.lzb   = 1'b0;
    bus.dotin = '0;
    prev_dig  = '0;
    prev_en   = '0;
    prev_dot  = '0;
    prev_ovf  = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_digits", 32'(bus.digits), 32'd0);
    chk("rst_en", 32'(bus.en), 32'd0);
    chk("rst_dot", 32'(bus.dot), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    rst = 1'b0;

    run_req(20'd123456, 1'b1, 1'b1, 6'b000000, -1);
    run_req(20'd42,     1'b1, 1'b1, 6'b000100, -1);
    run_req(20'hABCDE,  1'b0, 1'b1, 6'b000000, -1);
    run_req(20'h00000,  1'b0, 1'b1, 6'b000000, -1);
    run_req(20'd1000000, 1'b1, 1'b1, 6'b000000, -1);
    run_req(20'd7,      1'b1, 1'b1, 6'b000000, -1);
    run_req(20'd999999, 1'b1, 1'b0, 6'b100001, -1);
    run_req(20'h12345,  1'b1, 1'b1, 6'b000000, 5);
    run_req(20'h00F00,  1'b0, 1'b0, 6'b000010, 1);

    // Reset mid-conversion: no completion, display dark.
    @(negedge clk);
    bus.value = 20'd555555;
    bus.mode  = 1'b1;
    bus.lzb   = 1'b1;
    bus.dotin = 6'b000011;
    bus.load  = 1'b1;
    saw_done  = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      bus.load = 1'b0;
      if (n == 10) rst = 1'b1;
      if (n == 11) rst = 1'b0;
      if (bus.done === 1'b1) saw_done = 1'b1;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    chk("abort_digits", 32'(bus.digits), 32'd0);
    chk("abort_en", 32'(bus.en), 32'd0);
    chk("abort_dot", 32'(bus.dot), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    prev_dig = '0;
    prev_en  = '0;
    prev_dot = '0;
    prev_ovf = 1'b0;
    run_req(20'd65535, 1'b1, 1'b1, 6'b000000, -1);

    for (int k = 0; k < 40; k++) begin
      logic [19:0] v;
      logic [5:0]  d;
      case ($urandom_range(0, 3))
        0:       v = 20'($urandom_range(0, 20'hFFFFF));
        1:       v = 20'($urandom_range(0, 300));
        2:       v = 20'($urandom_range(999990, 1000010));
        default: v = 20'($urandom_range(0, 99999));
      endcase
      d = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
      run_req(v, 1'($urandom), 1'($urandom), d, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/hex_disp_ctrl.md
HEX_DISP_CTRL -- requirements
Module: hex_disp_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of 7-segment digit positions driven.
REQ-002 SHALL have parameter VALUE_W, default 20, binary input width.
REQ-003 SHALL have port CLK  in  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RST  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port VALUE  in  VALUE_W  binary value to display, sampled only on accepted LOAD.
REQ-006 SHALL have port LOAD  in  1  single-cycle request to convert and display VALUE.
REQ-007 SHALL have port MODE  in  1  0=hex, 1=decimal; sampled with VALUE.
REQ-008 SHALL have port LZB  in  1  1=leading-zero blanking enabled; sampled with VALUE.
REQ-009 SHALL have port DOTIN  in  NUM_DIGITS  decimal-point request per digit; sampled with VALUE.
REQ-010 SHALL have port DIGITS  out  4*NUM_DIGITS  nibble per digit, digit i at [4i+3:4i], digit 0 rightmost; feeds per-digit decoder DIN.
REQ-011 SHALL have port EN  out  NUM_DIGITS  per-digit enable (1=lit); feeds decoder EN.
REQ-012 SHALL have port DOT  out  NUM_DIGITS  per-digit decimal point; feeds decoder DOT.
REQ-013 SHALL have port BUSY  out  1  high while a request is in progress.
REQ-014 SHALL have port DONE  out  1  one-cycle pulse on the edge new DIGITS/EN/DOT take effect.
REQ-015 SHALL have port OVF  out  1  decimal value exceeded 999999; held until next commit.

Function
REQ-016 SHALL implement FSM states IDLE, CONV, COMMIT; LOAD accepted only in IDLE.
REQ-017 On LOAD in IDLE SHALL capture VALUE, MODE, LZB, DOTIN, set BUSY; MODE=1 -> CONV, MODE=0 -> COMMIT.
REQ-018 CONV SHALL run shift-add-3 binary-to-BCD, one bit per cycle, exactly VALUE_W cycles, then COMMIT.
REQ-019 COMMIT SHALL update DIGITS, EN, DOT, OVF, pulse DONE, clear BUSY, return to IDLE, all on one edge.
REQ-020 Latency LOAD edge -> commit edge SHALL be 22 cycles decimal, 2 cycles hex (VALUE_W=20).
REQ-021 Hex mode: digit i = VALUE[4i+3:4i]; digits beyond VALUE_W bits SHALL be 0.
REQ-022 Decimal OVF SHALL be decided by captured VALUE > 999999; when OVF=1, EN SHALL be all zero, DIGITS all zero.
REQ-023 LZB=1: digits above the most significant nonzero digit SHALL be blanked (EN=0); digit 0 always lit; any digit with DOTIN set, and all digits below it, never blanked.
REQ-024 LZB=0 and no OVF: EN SHALL be all ones.
REQ-025 DOT SHALL equal captured DOTIN at commit; OVF forces DOT to zero.
REQ-026 DIGITS/EN/DOT SHALL hold previous committed values throughout BUSY (no partial results visible).
REQ-027 LOAD while BUSY SHALL be ignored with no side effect; LOAD on the COMMIT edge is also ignored.

Reset
REQ-028 On RST: state IDLE, DIGITS=0, EN=0 (display dark), DOT=0, BUSY=0, DONE=0, OVF=0.
REQ-029 RST during CONV SHALL abort conversion; no DONE pulse issued for the aborted request.
REQ-030 RST SHALL take priority over LOAD on the same edge.

Structure
REQ-031 Shared package SHALL hold NUM_DIGITS, VALUE_W, DEC_MAX=999999 and the FSM state encoding.
REQ-032 BCD conversion SHALL be a sub-module bin2bcd_seq (start/busy/done, VALUE_W in, 4*NUM_DIGITS out).

Verification
REQ-033 Decimal 123456, LZB=1 -> after 22 cycles DIGITS=24'h123456, EN=6'b111111, DONE one cycle, OVF=0.
REQ-034 Decimal 42, LZB=1, DOTIN=6'b000100 -> DIGITS=24'h000042, EN=6'b000111, DOT=6'b000100.
REQ-035 Hex 20'hABCDE, LZB=1 -> after 2 cycles DIGITS=24'h0ABCDE, EN=6'b011111; value 0 LZB=1 -> EN=6'b000001.
REQ-036 Decimal 1000000 -> OVF=1, EN=0, DIGITS=0; following decimal 7 clears OVF, DIGITS=24'h000007.
REQ-037 LOAD at cycle 5 of a decimal conversion -> ignored, original result committed at cycle 22; RST at cycle 10 -> no DONE, outputs zero, next LOAD works normally.
